// File: rtl/fnd_bcd_scan_ctrl_if.sv
// Bus between the value source / FND pins and fnd_bcd_scan_ctrl.
// Handshake: the source raises load with bin valid. The request is taken
// only on a clock edge where the controller is idle (busy=0). While busy=1,
// load is ignored, with no queueing. done pulses for one cycle when bcd
// takes the new result.
interface fnd_bcd_scan_ctrl_if;
    logic [11:0] bin;
    logic        load;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic [3:0]  com;
    logic [7:0]  seg_7;
    logic [1:0]  state;   // conversion FSM state: 0 IDLE, 1 ADJ, 2 SHF, 3 DONE

    modport master (
        output bin, load,
        input  busy, done, bcd, com, seg_7, state
    );

    modport slave (
        input  bin, load,
        output busy, done, bcd, com, seg_7, state
    );
endinterface

// File: rtl/fnd_bcd_scan_ctrl.sv
// 12-bit binary to BCD converter (shift-add-3) driving a 4-digit
// common-anode seven-segment display through a scanned digit multiplexer.
module fnd_bcd_scan_ctrl #(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter bit          BLANK_LEAD = 1'b1
) (
    input logic               clk,
    input logic               reset_n,
    fnd_bcd_scan_ctrl_if.slave bus
);
    localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADJ  = 2'd1,
        SHF  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic [11:0]   shreg;
    logic [15:0]   work;
    logic [3:0]    bit_cnt;
    logic [15:0]   bcd_q;
    logic          done_q;
    logic          busy_q;
    logic [15:0]   work_adj;
    logic [15:0]   work_shf;
    logic [PW-1:0] presc;
    logic [1:0]    index;
    logic [3:0]    nib;
    logic          blank;

    // Add 3 to every working nibble above 4; nibbles are independent, no carry between them.
    always_comb begin
        work_adj = work;
        for (int k = 0; k < 4; k++) begin
            if (work[k*4 +: 4] > 4'd4) begin
                work_adj[k*4 +: 4] = work[k*4 +: 4] + 4'd3;
            end
        end
    end

    // The working BCD after shifting in the next binary MSB.
    assign work_shf = {work[14:0], shreg[11]};

    // Conversion FSM. bcd and done are loaded on the edge that enters DONE,
    // so the display only ever sees complete results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shreg   <= '0;
            work    <= '0;
            bit_cnt <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.load) begin
                        shreg   <= bus.bin;
                        work    <= '0;
                        bit_cnt <= '0;
                        busy_q  <= 1'b1;
                        state   <= ADJ;
                    end
                end
                ADJ: begin
                    work  <= work_adj;
                    state <= SHF;
                end
                SHF: begin
                    work    <= work_shf;
                    shreg   <= {shreg[10:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd11) begin
                        bcd_q  <= work_shf;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= ADJ;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running digit-slot prescaler and digit index, independent of the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            index <= 2'd0;
        end else if (presc == TERM) begin
            presc <= '0;
            index <= index + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Select the nibble of the active digit; leading zeros above it decide blanking.
    always_comb begin
        nib   = bcd_q[3:0];
        blank = 1'b0;
        case (index)
            2'd0: begin nib = bcd_q[3:0];   blank = 1'b0;                  end
            2'd1: begin nib = bcd_q[7:4];   blank = (bcd_q[15:4]  == '0);  end
            2'd2: begin nib = bcd_q[11:8];  blank = (bcd_q[15:8]  == '0);  end
            2'd3: begin nib = bcd_q[15:12]; blank = (bcd_q[15:12] == '0);  end
            default: begin nib = bcd_q[3:0]; blank = 1'b0;                 end
        endcase
    end

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 8'hC0;
            4'd1:    seg_decode = 8'hF9;
            4'd2:    seg_decode = 8'hA4;
            4'd3:    seg_decode = 8'hB0;
            4'd4:    seg_decode = 8'h99;
            4'd5:    seg_decode = 8'h92;
            4'd6:    seg_decode = 8'h82;
            4'd7:    seg_decode = 8'hF8;
            4'd8:    seg_decode = 8'h80;
            4'd9:    seg_decode = 8'h90;
            default: seg_decode = 8'hFF;
        endcase
    endfunction

    assign bus.com   = ~(4'b0001 << index);
    assign bus.seg_7 = (BLANK_LEAD && blank) ? 8'hFF : seg_decode(nib);
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.bcd   = bcd_q;
    assign bus.state = state;
endmodule

// File: tb/tb_fnd_bcd_scan_ctrl.sv
// Bench for fnd_bcd_scan_ctrl: two instances (leading-zero blanking on and off)
// share stimulus and are compared every cycle against a decimal reference model.
module tb_fnd_bcd_scan_ctrl;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    bit   run_chk = 1'b0;

    fnd_bcd_scan_ctrl_if bus_b ();
    fnd_bcd_scan_ctrl_if bus_n ();

    fnd_bcd_scan_ctrl #(.SCAN_DIV(SD), .BLANK_LEAD(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b.slave)
    );
    fnd_bcd_scan_ctrl #(.SCAN_DIV(SD), .BLANK_LEAD(1'b0)) dut_n (
        .clk(clk), .reset_n(reset_n), .bus(bus_n.slave)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model state
    int cnt = 0;       // cycles of busy left; 25 after an accepted load
    int pend = 0;      // value being converted
    int exp_val = 0;   // value currently shown in bcd
    int t = 0;         // clock edges since reset release

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 0; pend <= 0; exp_val <= 0; t <= 0;
        end else begin
            t <= t + 1;
            if (cnt == 0) begin
                if (bus_b.load) begin
                    cnt  <= 25;
                    pend <= int'(bus_b.bin);
                end
            end else begin
                cnt <= cnt - 1;
                if (cnt == 2) exp_val <= pend;
            end
        end
    end

    function automatic logic [15:0] to_bcd(input int v);
        return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic logic [7:0] exp_seg(input int v, input int k, input bit blank_on);
        logic [7:0] tbl [10];
        int p;
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        p = 10 ** k;
        if (blank_on && k > 0 && v < p) return 8'hFF;
        return tbl[(v / p) % 10];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // scoreboard: every falling edge, both instances against the model
    always @(negedge clk) begin
        if (run_chk) begin
            int k;
            logic [3:0] ec;
            k  = (t / SD) % 4;
            ec = ~(4'b0001 << k);
            check("busy_b", 32'(bus_b.busy), 32'(cnt != 0));
            check("done_b", 32'(bus_b.done), 32'(cnt == 1));
            check("bcd_b",  32'(bus_b.bcd),  32'(to_bcd(exp_val)));
            check("com_b",  32'(bus_b.com),  32'(ec));
            check("seg_b",  32'(bus_b.seg_7), 32'(exp_seg(exp_val, k, 1'b1)));
            check("busy_n", 32'(bus_n.busy), 32'(cnt != 0));
            check("bcd_n",  32'(bus_n.bcd),  32'(to_bcd(exp_val)));
            check("com_n",  32'(bus_n.com),  32'(ec));
            check("seg_n",  32'(bus_n.seg_7), 32'(exp_seg(exp_val, k, 1'b0)));
        end
    end

    // driver tasks
    task automatic drive(input logic [11:0] v, input logic l);
        bus_b.bin = v; bus_b.load = l;
        bus_n.bin = v; bus_n.load = l;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_load(input logic [11:0] v);
        drive(v, 1'b1);
        tick(1);
        drive(v, 1'b0);
    endtask

    initial begin
        int dones;
        drive(12'd0, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus_b.busy), 32'd0);
        check("rst_bcd",  32'(bus_b.bcd),  32'h0000);
        check("rst_com",  32'(bus_b.com),  32'hE);
        check("rst_seg",  32'(bus_b.seg_7), 32'hC0);
        run_chk = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(20);

        // full-scale conversion
        pulse_load(12'd4095);
        tick(30);

        // load while busy is ignored
        dones = 0;
        pulse_load(12'd9);
        if (bus_b.done) dones++;
        for (int i = 0; i < 4; i++) begin tick(1); if (bus_b.done) dones++; end
        drive(12'd1234, 1'b1);
        tick(1); if (bus_b.done) dones++;
        drive(12'd1234, 1'b0);
        for (int i = 0; i < 35; i++) begin tick(1); if (bus_b.done) dones++; end
        check("one_done", 32'(dones), 32'd1);
        check("bcd_0009", 32'(bus_b.bcd), 32'h0009);

        // blanking patterns
        pulse_load(12'd7);
        tick(45);
        pulse_load(12'd1005);
        tick(45);

        // reset in the middle of a conversion
        pulse_load(12'd300);
        tick(30);
        pulse_load(12'd777);
        tick(9);
        reset_n = 1'b0;
        #1;
        check("mid_busy", 32'(bus_b.busy), 32'd0);
        check("mid_bcd",  32'(bus_b.bcd),  32'h0000);
        tick(3);
        reset_n = 1'b1;
        tick(30);
        pulse_load(12'd777);
        tick(30);
        check("bcd_0777", 32'(bus_b.bcd), 32'h0777);

        // random values, load pulses and held loads
        for (int n = 0; n < 30; n++) begin
            drive(12'($urandom_range(0, 4095)), 1'b1);
            tick($urandom_range(1, 30));
            drive(12'($urandom_range(0, 4095)), 1'b0);
            tick($urandom_range(0, 30));
        end
        tick(30);

        run_chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
